tetris_input_arbiter: RTL and testbench



---
 rtl/tetris_input_arbiter_if.sv | 26 ++
 rtl/tetris_input_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_tetris_input_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_input_arbiter_if.sv
// tetris_input_arbiter_if
//   Command-side bus between the input arbiter and the game core.
//   key_valid/key_code : UART keystroke strobe and ASCII byte (into arbiter)
//   ready              : game core is waiting for a command (into arbiter)
//   ctrl               : current command, control_type encoding (from arbiter)
//   fifo_level         : number of queued events (from arbiter)
//   overflow           : one-cycle pulse, an event was discarded (from arbiter)
//   slave  modport : the arbiter
//   master modport : whoever drives keys/ready and consumes ctrl
interface tetris_input_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          key_valid;
  logic [7:0]    key_code;
  logic          ready;
  logic [3:0]    ctrl;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  modport slave  (input  key_valid, key_code, ready,
                  output ctrl, fifo_level, overflow);
  modport master (output key_valid, key_code, ready,
                  input  ctrl, fifo_level, overflow);
endinterface

// File: rtl/tetris_input_arbiter.sv
// tetris_btn_debounce
//   One button lane: 2-FF synchronizer followed by a stable-sample counter.
//   clk, reset_n : clock, async active-low reset
//   btn_raw      : asynchronous raw button level
//   rise         : high in the cycle whose edge flips the debounced level 0->1
module tetris_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          sync1, sync2, level;
  logic [CW-1:0] cnt;
  logic          flip;

  // cnt holds the number of differing samples already seen; the current
  // differing sample is the DEBOUNCE_CYCLES-th one when cnt == N-1.
  assign flip = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise = flip && !level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// tetris_input_arbiter
//   Merges debounced push buttons, UART keys and a gravity timer into one
//   command stream for the game core, queued through a small FIFO.
//   clk, reset_n : clock, async active-low reset
//   btn[3:0]     : raw buttons (0 LEFT, 1 RIGHT, 2 ROTATE, 3 DROP)
//   pause        : freezes gravity and command issue
//   bus          : key input, ready/ctrl handshake, fifo_level, overflow
module tetris_input_arbiter #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int GRAVITY_CYCLES  = 50_000_000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [3:0]             btn,
  input  logic                   pause,
  tetris_input_arbiter_if.slave  bus
);
  localparam int NUM_BTN = 4;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  localparam int GW      = $clog2(GRAVITY_CYCLES) + 1;

  localparam logic [3:0] C_NONE       = 4'd0;
  localparam logic [3:0] C_LEFT       = 4'd1;
  localparam logic [3:0] C_RIGHT      = 4'd2;
  localparam logic [3:0] C_DOWN       = 4'd3;
  localparam logic [3:0] C_DROP       = 4'd4;
  localparam logic [3:0] C_HOLD       = 4'd5;
  localparam logic [3:0] C_ROTATE     = 4'd6;
  localparam logic [3:0] C_ROTATE_REV = 4'd7;
  localparam logic [3:0] C_BAR        = 4'd8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  // ---------------- button lanes ----------------
  logic [NUM_BTN-1:0] btn_rise, pend, pend_clr;
  logic [3:0]         btn_cmd;
  logic               found;

  tetris_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [NUM_BTN-1:0] (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (btn),
    .rise    (btn_rise)
  );

  function automatic logic [3:0] btn_map(input int idx);
    case (idx)
      0:       return C_LEFT;
      1:       return C_RIGHT;
      2:       return C_ROTATE;
      default: return C_DROP;
    endcase
  endfunction

  // Lowest-index pending button is the candidate when no key is pushing.
  always_comb begin
    found    = 1'b0;
    pend_clr = '0;
    btn_cmd  = C_NONE;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (pend[i] && !found) begin
        found       = 1'b1;
        pend_clr[i] = 1'b1;
        btn_cmd     = btn_map(i);
      end
    end
  end

  // ---------------- key map ----------------
  logic [3:0] key_cmd;
  logic       key_hit;

  always_comb begin
    key_cmd = C_NONE;
    case (bus.key_code)
      8'h61:   key_cmd = C_LEFT;
      8'h64:   key_cmd = C_RIGHT;
      8'h73:   key_cmd = C_DOWN;
      8'h20:   key_cmd = C_DROP;
      8'h63:   key_cmd = C_HOLD;
      8'h77:   key_cmd = C_ROTATE;
      8'h71:   key_cmd = C_ROTATE_REV;
      8'h62:   key_cmd = C_BAR;
      default: key_cmd = C_NONE;
    endcase
  end
  assign key_hit = bus.key_valid && (key_cmd != C_NONE);

  // ---------------- FIFO / issue control ----------------
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] count;
  logic [0:0]    state;
  logic [3:0]    ctrl_q;
  logic          ovf_q;
  logic [GW-1:0] grav_cnt;
  logic          grav_pend;

  logic       push_req, push, pop, discard, load_down, drop_acc, grav_wrap;
  logic [3:0] push_cmd;

  assign push_req  = key_hit || (|pend);
  assign push_cmd  = key_hit ? key_cmd : btn_cmd;
  assign pop       = (state == S_IDLE) && !pause && (count != '0);
  assign load_down = (state == S_IDLE) && !pause && (count == '0) && grav_pend;
  // A same-cycle pop makes room for the push.
  assign push      = push_req && ((count != LW'(FIFO_DEPTH)) || pop);
  assign discard   = push_req && !push;
  assign drop_acc  = (state == S_HOLD) && bus.ready && (ctrl_q == C_DROP);
  assign grav_wrap = !pause && (grav_cnt == GW'(GRAVITY_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      pend   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(push) - LW'(pop);
      ovf_q <= discard;
      // A key push leaves button events pending; a button push (or its
      // discard) consumes the pending bit. A new rise always wins.
      pend  <= (pend & ~(key_hit ? '0 : pend_clr)) | btn_rise;
    end
  end

  // Gravity: an accepted DROP restarts the period for the new piece. A wrap
  // in the same cycle DOWN is loaded re-arms the flag so that tick survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grav_cnt  <= '0;
      grav_pend <= 1'b0;
    end else if (drop_acc) begin
      grav_cnt  <= '0;
      grav_pend <= 1'b0;
    end else begin
      if (!pause) grav_cnt <= grav_wrap ? '0 : grav_cnt + 1'b1;
      if (grav_wrap)      grav_pend <= 1'b1;
      else if (load_down) grav_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      ctrl_q <= C_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            ctrl_q <= mem[rd_ptr];
            state  <= S_HOLD;
          end else if (load_down) begin
            ctrl_q <= C_DOWN;
            state  <= S_HOLD;
          end
        end
        default: begin
          if (bus.ready) begin
            ctrl_q <= C_NONE;
            state  <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.ctrl       = ctrl_q;
  assign bus.fifo_level = count;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_tetris_input_arbiter.sv
module tb_tetris_input_arbiter;
  localparam int D = 4, G = 20, DEPTH = 4;
  localparam logic [3:0] NONE = 0, LEFT = 1, RIGHT = 2, DOWN = 3, DROP = 4,
                         HOLD = 5, ROTATE = 6, ROTATE_REV = 7, BAR = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] btn = '0;
  logic       pause = 1'b0;

  tetris_input_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus();

  tetris_input_arbiter #(
    .DEBOUNCE_CYCLES(D), .GRAVITY_CYCLES(G), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn(btn), .pause(pause), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] btn_tab [4] = '{LEFT, RIGHT, ROTATE, DROP};
  logic [3:0] m_s1, m_s2, m_lvl, m_pend;
  int         m_cnt [4];
  logic [3:0] m_q [$];
  int         m_gcnt;
  bit         m_gpend;
  logic [3:0] m_ctrl;
  bit         m_ovf;

  function automatic logic [3:0] key_to_cmd(input logic [7:0] k);
    case (k)
      8'h61: return LEFT;
      8'h64: return RIGHT;
      8'h73: return DOWN;
      8'h20: return DROP;
      8'h63: return HOLD;
      8'h77: return ROTATE;
      8'h71: return ROTATE_REV;
      8'h62: return BAR;
      default: return NONE;
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_q.delete();
    m_gcnt = 0; m_gpend = 0; m_ctrl = NONE; m_ovf = 0;
  endtask

  task automatic model_step();
    bit         holding, pop, load_down, have_push;
    logic [3:0] pcmd, popv, rise;
    holding   = (m_ctrl != NONE);
    pop       = !holding && !pause && (m_q.size() > 0);
    load_down = !holding && !pause && (m_q.size() == 0) && m_gpend;
    have_push = 0; pcmd = NONE; popv = NONE;
    if (bus.key_valid && key_to_cmd(bus.key_code) != NONE) begin
      have_push = 1; pcmd = key_to_cmd(bus.key_code);
    end else begin
      for (int i = 0; i < 4; i++) if (m_pend[i]) begin
        have_push = 1; pcmd = btn_tab[i]; m_pend[i] = 1'b0; break;
      end
    end
    // debounce: level flips on the D-th consecutive differing sample
    rise = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] == D) begin
          m_lvl[i] = ~m_lvl[i]; m_cnt[i] = 0; rise[i] = m_lvl[i];
        end
      end else m_cnt[i] = 0;
    end
    m_pend = m_pend | rise;
    m_s2 = m_s1; m_s1 = btn;
    if (pop) popv = m_q.pop_front();
    m_ovf = 0;
    if (have_push) begin
      if (m_q.size() < DEPTH) m_q.push_back(pcmd);
      else m_ovf = 1;
    end
    if (m_ctrl == DROP && bus.ready) begin
      m_gcnt = 0; m_gpend = 0;
    end else begin
      if (load_down) m_gpend = 0;
      if (!pause) begin
        if (m_gcnt == G - 1) begin m_gcnt = 0; m_gpend = 1; end
        else m_gcnt++;
      end
    end
    if (holding) begin
      if (bus.ready) m_ctrl = NONE;
    end else if (pop) m_ctrl = popv;
    else if (load_down) m_ctrl = DOWN;
  endtask

  // ---------------- observation bookkeeping ----------------
  int         cyc = 0, ovf_n = 0, drop_cyc = -1;
  int         n_cmd [16];
  logic [3:0] prev_ctrl = NONE;
  logic [3:0] seen_q [$];
  int         down_cyc [$];

  task automatic tick(input bit kv, input logic [7:0] kc);
    bus.key_valid = kv; bus.key_code = kc;
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    cyc++;
    chk("ctrl", bus.ctrl, m_ctrl);
    chk("fifo_level", bus.fifo_level, m_q.size());
    chk("overflow", bus.overflow, m_ovf);
    if (bus.ctrl != NONE && prev_ctrl == NONE) begin
      n_cmd[bus.ctrl]++;
      seen_q.push_back(bus.ctrl);
      if (bus.ctrl == DOWN) down_cyc.push_back(cyc);
      if (bus.ctrl == DROP) drop_cyc = cyc;
    end
    if (bus.overflow === 1'b1) ovf_n++;
    prev_ctrl = bus.ctrl;
    bus.key_valid = 1'b0;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 16; i++) n_cmd[i] = 0;
    seen_q.delete(); down_cyc.delete(); ovf_n = 0; drop_cyc = -1;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ctrl", bus.ctrl, NONE);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_ovf", bus.overflow, 0);
    model_reset();
    btn = '0; pause = 1'b0; bus.ready = 1'b1;
    bus.key_valid = 1'b0; bus.key_code = '0;
    prev_ctrl = NONE;
    clear_obs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [7:0] rkeys [10] = '{8'h61, 8'h64, 8'h73, 8'h20, 8'h63, 8'h77, 8'h71, 8'h62, 8'h41, 8'h00};
  logic [7:0] okeys [6]  = '{8'h61, 8'h64, 8'h73, 8'h77, 8'h63, 8'h71};
  logic [3:0] oexp  [5]  = '{LEFT, RIGHT, DOWN, ROTATE, HOLD};

  initial begin
    bus.ready = 1'b1; bus.key_valid = 1'b0; bus.key_code = '0;
    @(negedge clk);

    // key latency: strobe, then LEFT for exactly one cycle
    do_reset();
    tick(1, 8'h61); chk("lat_strobe", bus.ctrl, NONE);
    tick(0, 0);     chk("lat_left", bus.ctrl, LEFT);
    tick(0, 0);     chk("lat_after", bus.ctrl, NONE);

    // glitch then bounce on btn[1]
    do_reset();
    btn[1] = 1'b1; repeat (3) tick(0, 0);
    btn[1] = 1'b0; repeat (10) tick(0, 0);
    chk("glitch_right", n_cmd[RIGHT], 0);
    btn[1] = 1'b1; tick(0, 0);
    btn[1] = 1'b0; tick(0, 0);
    btn[1] = 1'b1; repeat (11) tick(0, 0);
    btn[1] = 1'b0; repeat (12) tick(0, 0);
    chk("bounce_right", n_cmd[RIGHT], 1);

    // queue fill and overflow with ready low, then drain
    do_reset();
    bus.ready = 1'b0;
    seen_q.delete();
    foreach (okeys[i]) tick(1, okeys[i]);
    chk("ovf_level", bus.fifo_level, 4);
    chk("ovf_hold", bus.ctrl, LEFT);
    chk("ovf_pulses", ovf_n, 1);
    bus.ready = 1'b1;
    repeat (12) tick(0, 0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("ovf_seq%0d", i), (i < seen_q.size()) ? seen_q[i] : 4'hF, oexp[i]);

    // gravity period and pause freeze
    do_reset();
    for (int i = 0; i < 80 && down_cyc.size() < 3; i++) tick(0, 0);
    chk("grav_three", down_cyc.size() >= 3, 1);
    if (down_cyc.size() >= 3) begin
      chk("grav_gap1", down_cyc[1] - down_cyc[0], 20);
      chk("grav_gap2", down_cyc[2] - down_cyc[1], 20);
      pause = 1'b1;
      repeat (30) tick(0, 0);
      chk("pause_nodown", down_cyc.size(), 3);
      pause = 1'b0;
      for (int i = 0; i < 40 && down_cyc.size() < 4; i++) tick(0, 0);
      chk("pause_seen", down_cyc.size() >= 4, 1);
      if (down_cyc.size() >= 4) chk("pause_gap", down_cyc[3] - down_cyc[2], 50);
    end

    // DROP accepted mid-period restarts gravity: accept edge is one after
    // DROP shows, the wrap is 20 edges later and DOWN loads one edge after that
    do_reset();
    for (int i = 0; i < 30 && m_gcnt != 13; i++) tick(0, 0);
    tick(1, 8'h20);
    down_cyc.delete();
    for (int i = 0; i < 40 && down_cyc.size() < 1; i++) tick(0, 0);
    chk("drop_seen", (drop_cyc > 0) && (down_cyc.size() == 1), 1);
    if (down_cyc.size() == 1) chk("drop_gap", down_cyc[0] - drop_cyc, 22);

    // key and button edge in the same cycle: key first
    do_reset();
    btn[0] = 1'b1;
    for (int i = 0; i < 10 && !(m_s2[0] != m_lvl[0] && m_cnt[0] == D - 1); i++) tick(0, 0);
    tick(1, 8'h63);
    repeat (6) tick(0, 0);
    chk("same_first", (seen_q.size() > 0) ? seen_q[0] : 4'hF, HOLD);
    chk("same_second", (seen_q.size() > 1) ? seen_q[1] : 4'hF, LEFT);
    btn[0] = 1'b0;

    // asynchronous reset with commands queued and held
    bus.ready = 1'b0;
    tick(1, 8'h61); tick(1, 8'h64); tick(1, 8'h73);
    chk("mid_level", bus.fifo_level, 2);
    do_reset();
    repeat (5) tick(0, 0);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
      bus.ready = 1'($urandom_range(0, 1));
      pause     = ($urandom_range(0, 19) == 0);
      tick($urandom_range(0, 4) == 0, rkeys[$urandom_range(0, 9)]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
